int_to_float: RTL and testbench

Sequential encoder from 12-bit unsigned integers to the team's 8-bit float format: exponent [7:5], mantissa [4:0], value = mantissa × 2^exponent. This is the same format that `float_add` consumes. The block is the producer side of that datapath. It turns integer sensor or counter values into operands for `float_add`, normalising with one right-shift per cycle and truncating. A valid/ready handshake sits on both sides.

---
 rtl/int_to_float.sv | 86 ++++++++
 tb/tb_int_to_float.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/int_to_float.sv
// Sequential 12-bit unsigned integer to {exp[2:0], mant[4:0]} float encoder.
// Normalises with one right shift per cycle, truncating, with valid/ready on both sides.
module int_to_float (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [11:0] in_data,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  result,
   output logic        inexact
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state, state_nxt;
   logic [11:0] sh, sh_nxt;
   logic [2:0]  exp, exp_nxt;
   logic        sticky, sticky_nxt;
   logic [7:0]  result_nxt;
   logic        inexact_nxt;
   logic        fits;

   // Value fits the 5-bit mantissa once nothing remains above bit 4.
   assign fits      = (sh[11:5] == 7'd0);
   assign in_ready  = (state == IDLE) && rst_n;
   assign out_valid = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         sh      <= '0;
         exp     <= '0;
         sticky  <= 1'b0;
         result  <= '0;
         inexact <= 1'b0;
      end else begin
         state   <= state_nxt;
         sh      <= sh_nxt;
         exp     <= exp_nxt;
         sticky  <= sticky_nxt;
         result  <= result_nxt;
         inexact <= inexact_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      sh_nxt      = sh;
      exp_nxt     = exp;
      sticky_nxt  = sticky;
      result_nxt  = result;
      inexact_nxt = inexact;
      case (state)
         IDLE: begin
            if (in_valid) begin
               sh_nxt     = in_data;
               exp_nxt    = 3'd0;
               sticky_nxt = 1'b0;
               state_nxt  = SHIFT;
            end
         end
         SHIFT: begin
            if (fits) begin
               result_nxt  = {exp, sh[4:0]};
               inexact_nxt = sticky;
               state_nxt   = DONE;
            end else begin
               sh_nxt     = sh >> 1;
               sticky_nxt = sticky | sh[0];
               exp_nxt    = exp + 3'd1;
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A 12-bit input needs at most 7 shifts, so the exponent cannot wrap.
   a_exp_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
      (state == SHIFT && !fits) |-> (exp != 3'd7));

endmodule

// File: tb/tb_int_to_float.sv
// Scoreboard bench for int_to_float: driver pushes expected results, monitor pops on out_valid rise.
module tb_int_to_float;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [11:0] in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  result;
   logic        inexact;

   int_to_float dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .inexact(inexact)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] res;
      logic       inx;
      int         lat;
      int         acc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic prev_ov = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compare on each rising out_valid.
   always @(negedge clk) begin
      if (rst_n && out_valid && !prev_ov) begin
         if (q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("result", int'(result), int'(e.res));
            chk("inexact", int'(inexact), int'(e.inx));
            chk("latency", cyc - e.acc, e.lat);
         end
      end
      prev_ov <= out_valid;
   end

   task automatic issue(input logic [11:0] d);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [11:0] d, input logic [7:0] r, input logic x, input int lat);
      exp_t e;
      issue(d);
      e.res = r; e.inx = x; e.lat = lat; e.acc = cyc;
      q.push_back(e);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      chk("done_timeout", q.size(), 0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_inexact", int'(inexact), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", int'(in_ready), 1);

      // Directed vectors: data, result, inexact, latency (E+1)
      send(12'd0,    8'h00, 1'b0, 1); wait_done();
      send(12'd31,   8'h1F, 1'b0, 1); wait_done();
      send(12'd32,   8'h30, 1'b0, 2); wait_done();
      send(12'd63,   8'h3F, 1'b1, 2); wait_done();
      send(12'd64,   8'h50, 1'b0, 3); wait_done();
      send(12'd100,  8'h59, 1'b0, 3); wait_done();
      send(12'd101,  8'h59, 1'b1, 3); wait_done();
      send(12'd4095, 8'hFF, 1'b1, 8); wait_done();
      send(12'd3968, 8'hFF, 1'b0, 8); wait_done();

      // Back-pressure: output held, competing input ignored
      out_ready = 1'b0;
      send(12'd100, 8'h59, 1'b0, 3); wait_done();
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = 12'd7;
         @(negedge clk);
         chk("bp_result", int'(result), 8'h59);
         chk("bp_out_valid", int'(out_valid), 1);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_out_valid", int'(out_valid), 0);
      chk("release_in_ready", int'(in_ready), 1);
      send(12'd7, 8'h07, 1'b0, 1); wait_done();

      // Reset mid-SHIFT discards the in-flight value
      issue(12'd4095);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_result", int'(result), 0);
      chk("midrst_in_ready", int'(in_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_idle", int'(in_ready), 1);
      repeat (10) @(negedge clk);
      chk("midrst_no_output", int'(out_valid), 0);
      send(12'd5, 8'h05, 1'b0, 1); wait_done();

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
